// File: rtl/dcache_nway_controller.sv
// N-way set-associative write-back/write-allocate data cache controller with
// age-based true-LRU replacement and one-pulse memory request handshake.
module dcache_nway_controller #(
   parameter int WAYS      = 2,
   parameter int SETS      = 16,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   input  logic                 cpu_MemRead_i,
   input  logic                 cpu_MemWrite_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic [31:0]          mem_addr_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 27 - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, REFILL} state_t;

   state_t                    state_q, state_d;
   logic [WAYS-1:0][SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
   logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
   logic [TAG_W-1:0]          tag_d  [WAYS][SETS];
   logic [LINE_BITS-1:0]      line_q [WAYS][SETS];
   logic [LINE_BITS-1:0]      line_d [WAYS][SETS];
   logic [WAY_W-1:0]          age_q  [WAYS][SETS];
   logic [WAY_W-1:0]          age_d  [WAYS][SETS];
   logic [WAY_W-1:0]          victim_q, victim_d;
   logic                      mem_enable_q, mem_enable_d;
   logic                      mem_write_q, mem_write_d;
   logic [31:0]               mem_addr_q, mem_addr_d;
   logic [LINE_BITS-1:0]      mem_data_q, mem_data_d;

   logic [IDX_W-1:0]     idx;
   logic [TAG_W-1:0]     req_tag;
   logic [2:0]           word;
   logic                 req;
   logic                 hit;
   logic                 found;
   logic [WAY_W-1:0]     hit_way;
   logic [WAY_W-1:0]     victim;
   logic [LINE_BITS-1:0] hit_line;
   logic                 unused_addr_lsb;

   assign idx             = cpu_addr_i[5 +: IDX_W];
   assign req_tag         = cpu_addr_i[31 -: TAG_W];
   assign word            = cpu_addr_i[4:2];
   assign req             = cpu_MemRead_i | cpu_MemWrite_i;
   assign unused_addr_lsb = ^cpu_addr_i[1:0];

   // Victim: lowest-index invalid way, else the oldest (age == WAYS-1).
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = '0;
      found   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && tag_q[w][idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][idx]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < WAYS; w++)
            if (age_q[w][idx] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
   end

   assign hit_line    = line_q[hit_way][idx];
   assign cpu_data_o  = hit ? hit_line[{word, 5'b0} +: 32] : 32'h0;
   assign cpu_stall_o = (state_q != IDLE) || (req && !hit);

   // Hits only complete from IDLE; the REFILL cycle still holds the pipeline.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      line_d  = line_q;
      age_d   = age_q;
      if (state_q == IDLE && req && hit) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == hit_way)
               age_d[w][idx] = '0;
            else if (age_q[w][idx] < age_q[hit_way][idx])
               age_d[w][idx] = age_q[w][idx] + 1'b1;
         end
         if (cpu_MemWrite_i) begin
            line_d[hit_way][idx][{word, 5'b0} +: 32] = cpu_data_i;
            dirty_d[hit_way][idx]                    = 1'b1;
         end
      end
      if (state_q == RD_WAIT && mem_ack_i) begin
         line_d[victim_q][idx]  = mem_data_i;
         valid_d[victim_q][idx] = 1'b1;
         dirty_d[victim_q][idx] = 1'b0;
         tag_d[victim_q][idx]   = req_tag;
      end
   end

   always_comb begin
      state_d      = state_q;
      victim_d     = victim_q;
      mem_enable_d = 1'b0;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               victim_d     = victim;
               mem_enable_d = 1'b1;
               if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
                  state_d     = WB_REQ;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_q[victim][idx], idx, 5'b0};
                  mem_data_d  = line_q[victim][idx];
               end else begin
                  state_d     = RD_REQ;
                  mem_write_d = 1'b0;
                  mem_addr_d  = {req_tag, idx, 5'b0};
               end
            end
         end
         WB_REQ:  state_d = WB_WAIT;
         WB_WAIT: begin
            if (mem_ack_i) begin
               state_d      = RD_REQ;
               mem_enable_d = 1'b1;
               mem_write_d  = 1'b0;
               mem_addr_d   = {req_tag, idx, 5'b0};
            end
         end
         RD_REQ:  state_d = RD_WAIT;
         RD_WAIT: if (mem_ack_i) state_d = REFILL;
         REFILL:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         victim_q     <= '0;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               age_q[w][s] <= WAY_W'(w);
               tag_q[w][s] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         victim_q     <= victim_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         age_q        <= age_d;
         tag_q        <= tag_d;
      end
   end

   // Line data is qualified by valid, so it needs no reset.
   always_ff @(posedge clk_i) begin
      line_q <= line_d;
   end

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

endmodule

// File: doc/dcache_nway_controller.md
# dcache_nway_controller

Parametrised N-way set-associative, write-back, write-allocate data cache controller sitting between the CPU MEM stage and the 256-bit data memory. It generalises the fixed 2-way controller to configurable way count and set count, adds true-LRU age-based replacement and an explicit one-pulse memory request handshake. It drives `cpu_stall_o`, which freezes PC and all pipeline registers while a miss is serviced.

## Interface
- `WAYS`, 2, associativity; legal values 1, 2, 4
- `SETS`, 16, sets per way; power of two, >= 2
- `LINE_BITS`, 256, line width in bits; fixed to match memory bus
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `cpu_addr_i`  in  32  byte address from MEM stage
- `cpu_data_i`  in  32  store data
- `cpu_MemRead_i`  in  1  load request
- `cpu_MemWrite_i`  in  1  store request
- `cpu_data_o`  out  32  load data
- `cpu_stall_o`  out  1  hold pipeline
- `mem_data_i`  in  256  refill line, valid in ack cycle
- `mem_ack_i`  in  1  one-cycle completion pulse
- `mem_data_o`  out  256  victim line for write-back
- `mem_addr_o`  out  32  line-aligned address (bits [4:0] = 0)
- `mem_enable_o`  out  1  request pulse
- `mem_write_o`  out  1  request is write (qualifies `mem_enable_o`)

## Operation
- Address split: offset = [4:0], word = [4:2], index = next log2(SETS) bits, tag = remaining upper bits.
- Per line state: valid, dirty, tag, 256-bit data, age (log2(WAYS) bits; absent when WAYS=1).
- Hit: valid && tag match in any way of the indexed set. At most one way can match.
- Both MemRead and MemWrite high: treated as write.
- Read hit: `cpu_data_o` = selected word, combinational. Write hit: word written at clock edge, dirty set.
- Every hit (read or write) updates LRU: hit way age := 0; ways in set with age < old hit-way age increment; others unchanged.
- Victim on miss: lowest-index invalid way; otherwise way with age = WAYS-1.
- FSM states: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, REFILL.
  - IDLE: request && miss -> WB_REQ if victim valid && dirty, else RD_REQ.
  - WB_REQ: `mem_enable_o`=1, `mem_write_o`=1, address = {victim tag, index, 5'b0}, data = victim line; -> WB_WAIT.
  - WB_WAIT: hold address/data; on `mem_ack_i` -> RD_REQ.
  - RD_REQ: `mem_enable_o`=1, `mem_write_o`=0, address = {req tag, index, 5'b0}; -> RD_WAIT.
  - RD_WAIT: on `mem_ack_i` capture `mem_data_i` into victim way, valid=1, dirty=0, tag = req tag; -> REFILL.
  - REFILL: -> IDLE; request is then re-evaluated as a hit and completes (including LRU update and store merge).
- `cpu_stall_o` = (state != IDLE) || (request && miss).
- `mem_ack_i` outside WB_WAIT/RD_WAIT is ignored.
- Address and data inputs are held stable by the stalled pipeline for the whole miss.

## Timing
- Reset values: `cpu_stall_o`=0, `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `cpu_data_o`=0 while no hit; all valid=0, dirty=0, way w age = w; FSM = IDLE.
- Reset mid-miss: FSM returns to IDLE immediately, all lines invalidated, pending ack ignored.
- Hit latency: 0 stall cycles.
- Clean miss: stall = 1 (IDLE) + 1 (RD_REQ) + L (RD_WAIT incl. ack) + 1 (REFILL) cycles, L = memory ack latency.
- Dirty miss: adds 1 (WB_REQ) + L (WB_WAIT).
- `mem_enable_o` high exactly one cycle per memory transaction; `mem_addr_o`/`mem_data_o`/`mem_write_o` stable from request through ack.

## Test plan
- After reset, load 0x0000_0400 with memory ack latency 10 -> one read request at 0x400, stall 13 cycles, `cpu_data_o` = word 0 of returned line, no write request.
- Store 0xDEADBEEF to 0x404 then load 0x404 -> both hits, 0 stall, load returns 0xDEADBEEF, line dirty.
- WAYS=2, SETS=16: load 0x000, 0x200, 0x400 (same index 0) -> third miss evicts way holding 0x000 (LRU); touching 0x000 before the third access instead evicts 0x200.
- Dirty eviction: store to 0x000, then fill 0x200 and 0x400 -> write request at 0x000 carrying stored word, followed by read request at 0x400; stall = 2L+4.
- WAYS=4: fill four tags in set 3, hit order 0,1,2,3, then fifth tag -> victim is way 0; ages after refill form a permutation of 0..3.
- Assert `rst_i` during RD_WAIT, then pulse `mem_ack_i` -> FSM IDLE, `cpu_stall_o`=0, ack ignored, subsequent load to same address misses.
